// File: rtl/aes_pkg.sv
// Shared AES types, SubBytes FSM encoding and the forward/inverse S-box tables.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} subbytes_fsm_e;

    localparam aes_byte_t SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam aes_byte_t SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_subbytes_engine_if.sv
// Input/output handshake bundle of the SubBytes engine, plus flush and busy sideband.
interface aes_subbytes_engine_if;
    import aes_pkg::*;

    logic       flush;
    logic       in_valid;
    logic       in_ready;
    aes_state_t in_state;
    logic       in_inv;
    logic       out_valid;
    logic       out_ready;
    aes_state_t out_state;
    logic       busy;

    modport master (
        output flush, in_valid, in_state, in_inv, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  flush, in_valid, in_state, in_inv, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/aes_sbox_dual.sv
// One S-box lane: combinational forward/inverse byte substitution.
module aes_sbox_dual
    import aes_pkg::*;
(
    input  aes_byte_t in,
    input  logic      inv,
    output aes_byte_t out
);
    assign out = inv ? SBOX_INV[in] : SBOX_FWD[in];
endmodule

// File: rtl/aes_subbytes_engine.sv
// Multi-cycle AES SubBytes: substitutes NUM_LANES bytes per cycle over BEATS cycles,
// with valid/ready handshakes on both sides and a synchronous flush.
module aes_subbytes_engine
    import aes_pkg::*;
#(
    parameter int unsigned NUM_LANES = 4
) (
    input logic                  clk,
    input logic                  rst,
    aes_subbytes_engine_if.slave bus
);
    localparam int unsigned BEATS  = 16 / NUM_LANES;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LANE_W = 8 * NUM_LANES;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (NUM_LANES != 1 && NUM_LANES != 2 && NUM_LANES != 4 && NUM_LANES != 8
        && NUM_LANES != 16) begin : g_bad_lanes
        $error("aes_subbytes_engine: NUM_LANES must be 1, 2, 4, 8 or 16");
    end

    subbytes_fsm_e     state_q, state_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    aes_state_t        data_q, data_d;
    logic              inv_q, inv_d;
    logic              in_ready;
    logic              accept;
    logic [6:0]        base;
    logic [LANE_W-1:0] lane_in;
    logic [LANE_W-1:0] lane_out;

    assign base    = 7'(beat_cnt_q * LANE_W);
    assign lane_in = data_q[base +: LANE_W];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        aes_sbox_dual u_sbox (
            .in  (lane_in[8*i +: 8]),
            .inv (inv_q),
            .out (lane_out[8*i +: 8])
        );
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        data_d     = data_q;
        inv_d      = inv_q;
        in_ready   = 1'b0;

        unique case (state_q)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = bus.out_ready;
            default: in_ready = 1'b0;
        endcase
        if (bus.flush) begin
            in_ready = 1'b0;
        end
        accept = bus.in_valid && in_ready;

        case (state_q)
            BUSY: begin
                data_d[base +: LANE_W] = lane_out;
                if (beat_cnt_q == LAST_BEAT) begin
                    beat_cnt_d = '0;
                    state_d    = DONE;
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // A drain in DONE may coincide with the next accept; the accept wins.
        if (accept) begin
            data_d     = bus.in_state;
            inv_d      = bus.in_inv;
            beat_cnt_d = '0;
            state_d    = BUSY;
        end

        if (bus.flush) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            data_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            data_q     <= '0;
            inv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            data_q     <= data_d;
            inv_q      <= inv_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_state = data_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_aes_subbytes_engine.sv
// Drives five engines (NUM_LANES = 1, 2, 4, 8, 16) with shared stimulus and checks them
// against an S-box model derived from GF(2^8) inversion plus the affine map.
module tb_aes_subbytes_engine;
    import aes_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_inv;
    logic       out_ready;
    aes_state_t in_state;

    logic [4:0] ov;
    logic [4:0] rdy;
    logic [4:0] bsy;
    aes_state_t os [5];

    int checks = 0;
    int errors = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        aes_subbytes_engine_if u_if ();
        assign u_if.flush     = flush;
        assign u_if.in_valid  = in_valid;
        assign u_if.in_state  = in_state;
        assign u_if.in_inv    = in_inv;
        assign u_if.out_ready = out_ready;
        assign ov[g]  = u_if.out_valid;
        assign rdy[g] = u_if.in_ready;
        assign bsy[g] = u_if.busy;
        assign os[g]  = u_if.out_state;

        aes_subbytes_engine #(.NUM_LANES(1 << g)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if)
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return 8'((b << k) | (b >> (8 - k)));
    endfunction

    function automatic aes_state_t model_sub(input aes_state_t st, input logic inv);
        aes_state_t r;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = inv ? inv_tab[st[8*i +: 8]] : fwd_tab[st[8*i +: 8]];
        end
        return r;
    endfunction

    task automatic build_tables();
        logic [7:0] x;
        logic [7:0] s;
        for (int i = 0; i < 256; i++) begin
            x = 8'h00;
            for (int j = 1; j < 256; j++) begin
                if (gmul(8'(i), 8'(j)) == 8'h01) x = 8'(j);
            end
            s = x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
            fwd_tab[i] = s;
            inv_tab[s] = 8'(i);
        end
    endtask

    task automatic check(input string tag, input int idx, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Latency is counted with the accept edge as edge 1, so out_valid is first seen after
    // edge BEATS+1. out_ready stays high, so each result is valid for exactly one edge.
    task automatic run_txn(input aes_state_t st, input logic inv, input aes_state_t exp,
                           input string tag);
        in_state  = st;
        in_inv    = inv;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) check({tag, "_rdy"}, k, 128'(rdy[k]), 128'd1);
        for (int n = 1; n <= 18; n++) begin
            step();
            if (n == 1) begin
                in_valid = 1'b0;
                in_inv   = ~inv;
                in_state = ~st;
            end
            for (int k = 0; k < 5; k++) begin
                int lat;
                lat = (16 >> k) + 1;
                check({tag, "_valid"}, k, 128'(ov[k]), 128'(n == lat));
                if (n == lat) check({tag, "_data"}, k, os[k], exp);
            end
        end
    endtask

    initial begin
        aes_state_t a;
        aes_state_t b;
        aes_state_t e;
        logic       m;

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inv    = 1'b0;
        out_ready = 1'b0;
        in_state  = '0;
        build_tables();

        #2;
        for (int k = 0; k < 5; k++) begin
            check("reset_valid", k, 128'(ov[k]), 128'd0);
            check("reset_busy", k, 128'(bsy[k]), 128'd0);
            check("reset_state", k, os[k], 128'd0);
        end
        step();
        rst = 1'b0;
        step();
        for (int k = 0; k < 5; k++) check("post_reset_ready", k, 128'(rdy[k]), 128'd1);

        run_txn(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
                128'hd42711aee0bf98f1b8b45de51e415230, "fips_fwd");
        run_txn(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1,
                128'h193de3bea0f4e22b9ac68d2ae9f84808, "fips_inv");
        run_txn(128'h0, 1'b0, {16{8'h63}}, "zero_fwd");
        run_txn(128'h0000_0000_0000_0000_0000_0000_0000_ff53, 1'b0,
                128'h6363_6363_6363_6363_6363_6363_6363_16ed, "byte_fwd");
        run_txn({16{8'h63}}, 1'b1, 128'h0, "byte_inv");

        // Back-pressure on the 4-lane engine, then drain and accept on one edge.
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b0;
        in_inv    = 1'b0;
        in_state  = a;
        in_valid  = 1'b1;
        step();
        in_state = b;
        in_inv   = 1'b1;
        for (int n = 2; n <= 5; n++) begin
            step();
            check("bp_valid_rise", n, 128'(ov[2]), 128'(n == 5));
        end
        for (int c = 0; c < 10; c++) begin
            check("bp_hold_valid", c, 128'(ov[2]), 128'd1);
            check("bp_hold_data", c, os[2], model_sub(a, 1'b0));
            check("bp_hold_ready", c, 128'(rdy[2]), 128'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_drain_ready", 2, 128'(rdy[2]), 128'd1);
        step();
        in_valid = 1'b0;
        check("bp_reaccept_valid", 2, 128'(ov[2]), 128'd0);
        check("bp_reaccept_busy", 2, 128'(bsy[2]), 128'd1);
        for (int n = 2; n <= 5; n++) begin
            step();
            check("bp_next_valid", n, 128'(ov[2]), 128'(n == 5));
            if (n == 5) check("bp_next_data", 2, os[2], model_sub(b, 1'b1));
        end
        repeat (20) step();

        // Flush during the second BUSY cycle, with a competing input offered.
        a = {$urandom, $urandom, $urandom, $urandom};
        in_state = a;
        in_inv   = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_state = ~a;
        #1;
        check("flush_ready", 2, 128'(rdy[2]), 128'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_busy", 2, 128'(bsy[2]), 128'd0);
        check("flush_valid", 2, 128'(ov[2]), 128'd0);
        check("flush_state", 2, os[2], 128'd0);
        step();
        check("flush_no_accept", 2, 128'(bsy[2]), 128'd0);
        b = {$urandom, $urandom, $urandom, $urandom};
        run_txn(b, 1'b0, model_sub(b, 1'b0), "after_flush");

        // Asynchronous reset between edges while BUSY.
        a = {$urandom, $urandom, $urandom, $urandom};
        in_state = a;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 2, 128'(ov[2]), 128'd0);
        check("arst_busy", 2, 128'(bsy[2]), 128'd0);
        check("arst_state", 2, os[2], 128'd0);
        #2 rst = 1'b0;
        step();
        check("arst_ready", 2, 128'(rdy[2]), 128'd1);
        check("arst_idle", 2, 128'(bsy[2]), 128'd0);

        // Random regression: each state goes through and back with the opposite mode.
        for (int t = 0; t < 500; t++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            m = 1'($urandom_range(0, 1));
            e = model_sub(a, m);
            run_txn(a, m, e, "rand");
            run_txn(e, ~m, a, "roundtrip");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
